// File: rtl/merge2_arb_if.sv
// merge2_arb_if: handshake and status bundle for the two-to-one packet merge.
//   in0_*/in1_*  : child channels (data, valid, ready)
//   out_*        : parent channel (data, src tag, valid, ready)
//   cnt0/cnt1    : per-child accepted-packet counters
// The slave modport is the merge block's view; master is the surrounding
// environment (children plus parent).
interface merge2_arb_if #(
  parameter int W  = 9,
  parameter int CW = 16
);
  logic [W-1:0]  in0_data;
  logic          in0_valid;
  logic          in0_ready;
  logic [W-1:0]  in1_data;
  logic          in1_valid;
  logic          in1_ready;
  logic [W-1:0]  out_data;
  logic          out_src;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
    output in0_ready, in1_ready, out_data, out_src, out_valid, cnt0, cnt1
  );

  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready,
    input  in0_ready, in1_ready, out_data, out_src, out_valid, cnt0, cnt1
  );
endinterface

// File: rtl/merge2_arb.sv
// merge2_arb: merges packets from two child channels onto one parent channel.
// Round-robin arbitration picks at most one child per cycle; accepted packets
// are queued with their source tag in a small circular FIFO.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : merge2_arb_if.slave (child inputs, parent output, counters)
module merge2_arb #(
  parameter int W     = 9,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  merge2_arb_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [W-1:0]     mem_data_q [DEPTH];
  logic [DEPTH-1:0] mem_src_q;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [NW-1:0]    count_q, count_d;
  logic             prio_q, prio_d;
  logic [CW-1:0]    cnt0_q, cnt0_d;
  logic [CW-1:0]    cnt1_q, cnt1_d;

  logic             space_s;
  logic             grant0_s;
  logic             grant1_s;
  logic             acc0_s;
  logic             acc1_s;
  logic             push_s;
  logic             pop_s;
  logic [W-1:0]     push_data_s;

  // Arbitration, handshake and next-state computation.
  always_comb begin
    rd_d        = rd_q;
    wr_d        = wr_q;
    count_d     = count_q;
    prio_d      = prio_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    // space looks only at the stored count so out_ready never reaches inX_ready.
    space_s     = (count_q < DEPTH_N);
    grant0_s    = bus.in0_valid & (~bus.in1_valid | ~prio_q);
    grant1_s    = bus.in1_valid & (~bus.in0_valid |  prio_q);
    // Readies are forced low while reset is asserted.
    acc0_s      = ~rst & space_s & grant0_s;
    acc1_s      = ~rst & space_s & grant1_s;
    push_s      = acc0_s | acc1_s;
    pop_s       = (count_q != {NW{1'b0}}) & bus.out_ready;
    push_data_s = acc1_s ? bus.in1_data : bus.in0_data;

    if (acc0_s) begin
      prio_d = 1'b1;
      cnt0_d = cnt0_q + CW'(1);
    end else if (acc1_s) begin
      prio_d = 1'b0;
      cnt1_d = cnt1_q + CW'(1);
    end else begin
      prio_d = prio_q;
    end

    if (push_s) begin
      wr_d = (wr_q == LAST_PTR) ? {AW{1'b0}} : wr_q + AW'(1);
    end else begin
      wr_d = wr_q;
    end

    if (pop_s) begin
      rd_d = (rd_q == LAST_PTR) ? {AW{1'b0}} : rd_q + AW'(1);
    end else begin
      rd_d = rd_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers, occupancy, priority and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= {AW{1'b0}};
      wr_q    <= {AW{1'b0}};
      count_q <= {NW{1'b0}};
      prio_q  <= 1'b0;
      cnt0_q  <= {CW{1'b0}};
      cnt1_q  <= {CW{1'b0}};
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      prio_q  <= prio_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  // FIFO storage; entries are written on push and never cleared by a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= {W{1'b0}};
      end
      mem_src_q <= {DEPTH{1'b0}};
    end else if (push_s) begin
      mem_data_q[wr_q] <= push_data_s;
      mem_src_q[wr_q]  <= acc1_s;
    end
  end

  assign bus.in0_ready = acc0_s;
  assign bus.in1_ready = acc1_s;
  assign bus.out_data  = mem_data_q[rd_q];
  assign bus.out_src   = mem_src_q[rd_q];
  assign bus.out_valid = (count_q != {NW{1'b0}});
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;
endmodule

// File: tb/tb_merge2_arb.sv
module tb_merge2_arb;
  localparam int W     = 9;
  localparam int DEPTH = 2;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  merge2_arb_if #(.W(W), .CW(CW)) bus ();
  merge2_arb #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q   [$];   // {src, data} expected at the parent, in order
  logic [W:0] got_log [$];   // {src, data} actually popped

  int          m_count = 0;
  logic        m_prio  = 1'b0;
  logic [CW-1:0] m_cnt0 = '0;
  logic [CW-1:0] m_cnt1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: expected handshake from the spec, pushes to scoreboard.
  initial begin
    logic sp, g0, g1, e0, e1, pp;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_ready0", 32'(bus.in0_ready), 32'd0);
        check("rst_ready1", 32'(bus.in1_ready), 32'd0);
        check("rst_valid",  32'(bus.out_valid), 32'd0);
        exp_q.delete();
        m_count = 0; m_prio = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
      end else begin
        sp = (m_count < DEPTH);
        g0 = bus.in0_valid & (~bus.in1_valid | ~m_prio);
        g1 = bus.in1_valid & (~bus.in0_valid |  m_prio);
        e0 = sp & g0;
        e1 = sp & g1;
        pp = (m_count != 0) & bus.out_ready;
        check("m_ready0", 32'(bus.in0_ready), 32'(e0));
        check("m_ready1", 32'(bus.in1_ready), 32'(e1));
        check("m_valid",  32'(bus.out_valid), 32'(m_count != 0));
        check("m_cnt0",   32'(bus.cnt0), 32'(m_cnt0));
        check("m_cnt1",   32'(bus.cnt1), 32'(m_cnt1));
        if (e0) begin
          exp_q.push_back({1'b0, bus.in0_data});
          m_prio = 1'b1; m_cnt0 = m_cnt0 + 16'd1;
        end
        if (e1) begin
          exp_q.push_back({1'b1, bus.in1_data});
          m_prio = 1'b0; m_cnt1 = m_cnt1 + 16'd1;
        end
        m_count = m_count + ((e0 | e1) ? 1 : 0) - (pp ? 1 : 0);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the parent takes a packet.
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        got_log.push_back({bus.out_src, bus.out_data});
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_pkt", 32'({bus.out_src, bus.out_data}), 32'(e));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in0_data = '0; bus.in0_valid = 1'b0;
    bus.in1_data = '0; bus.in1_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data",  32'(bus.out_data),  32'd0);
    check("reset_cnt0",      32'(bus.cnt0),      32'd0);

    // Single packet from in0
    bus.in0_data = 9'h0C5; bus.in0_valid = 1'b1; bus.out_ready = 1'b1;
    #1 check("t2_ready0", 32'(bus.in0_ready), 32'd1);
    cyc();
    bus.in0_valid = 1'b0;
    check("t2_valid", 32'(bus.out_valid), 32'd1);
    check("t2_data",  32'(bus.out_data),  32'h0C5);
    check("t2_src",   32'(bus.out_src),   32'd0);
    check("t2_cnt0",  32'(bus.cnt0),      32'd1);
    // One in1 packet so the priority pointer returns to in0
    bus.in1_data = 9'h1AA; bus.in1_valid = 1'b1;
    cyc();
    bus.in1_valid = 1'b0;
    cyc(); cyc();

    // Both children continuously valid: grants alternate starting at in0
    got_log.delete();
    bus.in0_data = 9'h011; bus.in1_data = 9'h1F0;
    bus.in0_valid = 1'b1;  bus.in1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t3_ready0", 32'(bus.in0_ready), 32'((i % 2) == 0));
      check("t3_ready1", 32'(bus.in1_ready), 32'((i % 2) == 1));
      cyc();
    end
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    cyc(); cyc(); cyc();
    check("t3_cnt0", 32'(bus.cnt0), 32'd5);
    check("t3_cnt1", 32'(bus.cnt1), 32'd5);
    check("t3_npkt", 32'(got_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_log.size(); i++) begin
      check("t3_src_seq", 32'(got_log[i]), (i % 2) ? 32'h3F0 : 32'h011);
    end

    // Back-pressure: fill, stall, then drain
    bus.out_ready = 1'b0;
    bus.in0_data = 9'h022; bus.in1_data = 9'h133;
    bus.in0_valid = 1'b1;  bus.in1_valid = 1'b1;
    #1 check("t4_acc0", 32'({bus.in0_ready, bus.in1_ready}), 32'b10);
    cyc();
    check("t4_acc1", 32'({bus.in0_ready, bus.in1_ready}), 32'b01);
    cyc();
    check("t4_full_a", 32'({bus.in0_ready, bus.in1_ready}), 32'b00);
    check("t4_head",   32'(bus.out_data), 32'h022);
    cyc();
    check("t4_full_b", 32'({bus.in0_ready, bus.in1_ready}), 32'b00);
    bus.out_ready = 1'b1;
    #1 check("t4_popcyc", 32'({bus.in0_ready, bus.in1_ready}), 32'b00);
    cyc();
    check("t4_resume", 32'({bus.in0_ready, bus.in1_ready}), 32'b10);
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    cyc(); cyc(); cyc(); cyc();

    // Push and pop together at count=1
    bus.out_ready = 1'b0;
    bus.in0_data = 9'h055; bus.in0_valid = 1'b1;
    cyc();
    bus.in0_valid = 1'b0;
    bus.in1_data = 9'h166; bus.in1_valid = 1'b1; bus.out_ready = 1'b1;
    #1 check("t5_ready1", 32'(bus.in1_ready), 32'd1);
    check("t5_head", 32'(bus.out_data), 32'h055);
    cyc();
    bus.in1_valid = 1'b0; bus.out_ready = 1'b0;
    check("t5_valid", 32'(bus.out_valid), 32'd1);
    check("t5_pkt",   32'({bus.out_src, bus.out_data}), 32'h366);
    cyc();
    check("t5_hold", 32'({bus.out_src, bus.out_data}), 32'h366);
    bus.out_ready = 1'b1;
    cyc(); cyc();
    check("t5_empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset with two packets stored
    bus.out_ready = 1'b0;
    bus.in0_data = 9'h0AB; bus.in0_valid = 1'b1;
    cyc();
    bus.in0_data = 9'h0AC;
    cyc();
    check("t1_full", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t1_valid",  32'(bus.out_valid), 32'd0);
    check("t1_cnt0",   32'(bus.cnt0),      32'd0);
    check("t1_cnt1",   32'(bus.cnt1),      32'd0);
    check("t1_data",   32'(bus.out_data),  32'd0);
    check("t1_ready0", 32'(bus.in0_ready), 32'd0);
    cyc();
    check("t1_ready0_hold", 32'(bus.in0_ready), 32'd0);
    rst = 1'b0;
    bus.in0_valid = 1'b0;
    cyc();

    // Counter wrap on in1
    bus.out_ready = 1'b1;
    bus.in1_valid = 1'b1;
    bus.in1_data  = 9'h100;
    for (int i = 0; i < 65535; i++) begin
      cyc();
      bus.in1_data = 9'(i);
    end
    check("t6_cnt1_max", 32'(bus.cnt1), 32'h0000FFFF);
    cyc();
    bus.in1_valid = 1'b0;
    check("t6_cnt1_wrap", 32'(bus.cnt1), 32'h00000000);
    check("t6_cnt0",      32'(bus.cnt0), 32'h00000000);
    cyc(); cyc(); cyc();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
